instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 127 ++++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch stage: IDLE/FETCH/HOLD sequencer that owns pc,
// the registered instruction and the retired-instruction counter.
module instr_fetch #(
   parameter int DW = 16,
   parameter int AW = 15
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          run,
   output logic          imem_req,
   output logic [AW-1:0] imem_addr,
   input  logic          imem_ack,
   input  logic [DW-1:0] imem_rdata,
   output logic [DW-1:0] instr,
   output logic          instr_valid,
   input  logic          instr_ready,
   input  logic          instr_type,
   input  logic          cmd_j1,
   input  logic          cmd_j2,
   input  logic          cmd_j3,
   input  logic          zr,
   input  logic          ng,
   input  logic [AW-1:0] a_val,
   output logic [AW-1:0] pc,
   output logic [15:0]   retired
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_HOLD  = 2'd2
   } state_t;

   state_t        r_state;
   state_t        w_next;
   logic [AW-1:0] r_pc;
   logic [DW-1:0] r_instr;
   logic [15:0]   r_retired;

   logic          w_in_idle;
   logic          w_in_fetch;
   logic          w_in_hold;
   logic          w_capture;
   logic          w_retire;
   logic          w_cond;
   logic          w_taken;
   logic [AW-1:0] w_pc_inc;
   logic [AW-1:0] w_pc_next;

   assign w_in_idle  = (r_state == S_IDLE);
   assign w_in_fetch = (r_state == S_FETCH);
   assign w_in_hold  = (r_state == S_HOLD);

   assign w_capture = w_in_fetch & imem_ack;
   assign w_retire  = w_in_hold & instr_ready;

   // lt / eq / gt against the ALU result; only C-instructions may jump
   assign w_cond = (cmd_j1 & ng)
                 | (cmd_j2 & zr)
                 | (cmd_j3 & ~ng & ~zr);
   assign w_taken = instr_type & w_cond;

   assign w_pc_inc  = r_pc + {{(AW-1){1'b0}}, 1'b1};
   assign w_pc_next = w_taken ? a_val : w_pc_inc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (1'b1)
         w_in_idle: begin
            if (run) w_next = S_FETCH;
         end
         w_in_fetch: begin
            if (imem_ack) w_next = S_HOLD;
         end
         w_in_hold: begin
            if (instr_ready)
               w_next = run ? S_FETCH : S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      imem_req    = 1'b0;
      instr_valid = 1'b0;
      unique case (1'b1)
         w_in_fetch: imem_req    = 1'b1;
         w_in_hold:  instr_valid = 1'b1;
         default: begin
            imem_req    = 1'b0;
            instr_valid = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_instr <= '0;
      end else if (w_capture) begin
         r_instr <= imem_rdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc      <= '0;
         r_retired <= '0;
      end else if (w_retire) begin
         r_pc      <= w_pc_next;
         r_retired <= r_retired + 16'd1;
      end
   end

   assign imem_addr = r_pc;
   assign pc        = r_pc;
   assign instr     = r_instr;
   assign retired   = r_retired;

endmodule
